divsqrt_seq: RTL and testbench
==============================

DIVSQRT_SEQ -- requirements
Module: divsqrt_seq

Interface
REQ-001 Parameter NF, default 52: fraction width of the widest supported format.
REQ-002 Parameter LOGR, default 2: log2 of the divsqrt radix.
REQ-003 Parameter DIVCOPIES, default 2: iteration stages per clock.
REQ-004 Derived constants SHALL be:
- DIVCYCLES = ceil((NF+4)/(LOGR*DIVCOPIES)); this is 14 at the defaults.
- SQRTCYCLES = DIVCYCLES+1; this is 15 at the defaults.
- CW = $clog2(SQRTCYCLES+1).
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 FDivStartE  input  1  request to start a divide or square-root operation.
REQ-008 SqrtE  input  1  1 selects square root, 0 selects divide; sampled at accepted start.
REQ-009 SpecialCaseE  input  1  NaN/Inf/zero operand; result needs no iterations; sampled at accepted start.
REQ-010 FlushE  input  1  pipeline flush; aborts any operation.
REQ-011 StallM  input  1  downstream stall; holds the completed result.
REQ-012 IFDivStartE  output  1  one-cycle pulse that initializes the datapath registers.
REQ-013 FDivBusyE  output  1  stalls the upstream pipeline.
REQ-014 FDivDoneE  output  1  result valid.
REQ-015 SqrtM  output  1  captured SqrtE.
REQ-016 SpecialCaseM  output  1  captured SpecialCaseE.
REQ-017 StepCnt  output  CW  remaining iteration count.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY, DONE. It SHALL be binary-encoded.
REQ-019 A start SHALL be accepted only when all of these hold: state==IDLE, FDivStartE=1, FlushE=0.
REQ-020 IFDivStartE SHALL be combinational and SHALL equal 1 exactly in a cycle where a start is accepted.
REQ-021 On an accepted start, SqrtM and SpecialCaseM SHALL capture SqrtE and SpecialCaseE. They SHALL hold those values until the next accepted start.
REQ-022 On an accepted start with SpecialCaseE=1, the next state SHALL be DONE and StepCnt SHALL load 0.
REQ-023 On an accepted start with SpecialCaseE=0:
- the next state SHALL be BUSY;
- StepCnt SHALL load (SqrtE ? SQRTCYCLES : DIVCYCLES) - 1.
REQ-024 In BUSY with StepCnt!=0, StepCnt SHALL decrement by 1 per cycle. StepCnt SHALL never wrap below 0.
REQ-025 In BUSY with StepCnt==0, the next state SHALL be DONE. BUSY therefore lasts exactly DIVCYCLES (divide) or SQRTCYCLES (sqrt) cycles.
REQ-026 In DONE:
- FDivDoneE SHALL be 1;
- the state SHALL remain DONE while StallM=1;
- the state SHALL return to IDLE in the cycle after StallM=0.
REQ-027 FDivBusyE SHALL equal (state==BUSY) | (state==DONE & StallM). FDivBusyE SHALL NOT be asserted in the start cycle.
REQ-028 FDivStartE SHALL be ignored in BUSY and in DONE. It SHALL NOT restart or extend the operation.
REQ-029 FlushE=1 in any state SHALL force the next state to IDLE and StepCnt to 0. Flush SHALL take priority over start, iteration completion and the DONE hold.
REQ-030 FDivDoneE SHALL be 0 in IDLE and BUSY. Done SHALL never be produced for a flushed operation.
REQ-031 Latency, with the accepted start at cycle 0:
- divide: FDivDoneE SHALL first rise at cycle DIVCYCLES+1;
- sqrt: FDivDoneE SHALL first rise at cycle SQRTCYCLES+1;
- special case: FDivDoneE SHALL first rise at cycle 1.
REQ-032 Back-to-back operation: a new start SHALL be accepted only from IDLE, so at least one idle cycle SHALL separate DONE from the next start.

Reset
REQ-033 While reset=1 at a clock edge, the next state SHALL be IDLE.
REQ-034 While reset=1 at a clock edge, StepCnt, SqrtM and SpecialCaseM SHALL reset to 0.
REQ-035 After reset, FDivBusyE, FDivDoneE and IFDivStartE SHALL all be 0. This holds even if FDivStartE=1 during reset.
REQ-036 Reset SHALL take priority over FlushE and FDivStartE.
REQ-037 Reset asserted mid-operation SHALL abandon the operation without producing FDivDoneE.

Verification
REQ-038 Divide, defaults, StallM=0: pulse FDivStartE with SqrtE=0 at cycle 0 ->
- IFDivStartE=1 at cycle 0;
- FDivBusyE=1 at cycles 1-14, StepCnt runs 13 down to 0;
- FDivDoneE=1 at cycle 15 only;
- state is IDLE at cycle 16.
REQ-039 Sqrt: start with SqrtE=1 ->
- StepCnt loads 14;
- BUSY for 15 cycles;
- FDivDoneE at cycle 16;
- SqrtM=1 from cycle 1.
REQ-040 Special case: start with SpecialCaseE=1 ->
- no BUSY cycles;
- FDivDoneE=1 at cycle 1;
- SpecialCaseM=1.
REQ-041 Stall in DONE: hold StallM=1 for 3 cycles from cycle 15 of a divide ->
- FDivDoneE=1 and FDivBusyE=1 for cycles 15-17;
- FDivBusyE=0 at cycle 18 and FDivDoneE still 1;
- IDLE at cycle 19.
REQ-042 Flush and reset mid-operation:
- FlushE=1 at cycle 5 of a divide -> IDLE at cycle 6, StepCnt=0, FDivDoneE never asserted;
- FlushE=1 together with FDivStartE in IDLE -> IFDivStartE=0, no start accepted;
- reset=1 at cycle 7 of a sqrt -> IDLE and all outputs 0 at cycle 8, no FDivDoneE.
REQ-043 Start ignored when busy: FDivStartE held at 1 throughout a divide -> no restart in BUSY or DONE; the next IFDivStartE pulse occurs only after the state returns to IDLE.

Source files
------------

// File: rtl/divsqrt_seq.sv
// divsqrt_seq: sequencing FSM for the iterative divide / square-root unit.
// Counts iteration cycles, raises busy/done toward the pipeline and captures
// the operation kind for the downstream stage.
module divsqrt_seq #(
  parameter int NF        = 52,
  parameter int LOGR      = 2,
  parameter int DIVCOPIES = 2,
  localparam int DIVCYCLES  = (NF + 4 + LOGR*DIVCOPIES - 1) / (LOGR*DIVCOPIES),
  localparam int SQRTCYCLES = DIVCYCLES + 1,
  localparam int CW         = $clog2(SQRTCYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          FDivStartE,
  input  logic          SqrtE,
  input  logic          SpecialCaseE,
  input  logic          FlushE,
  input  logic          StallM,
  output logic          IFDivStartE,
  output logic          FDivBusyE,
  output logic          FDivDoneE,
  output logic          SqrtM,
  output logic          SpecialCaseM,
  output logic [CW-1:0] StepCnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, stateNext;
  logic [CW-1:0] stepCntNext;

  // Start acceptance; reset gating keeps the pulse low while reset is held.
  always_comb begin
    IFDivStartE = ~reset & (state == IDLE) & FDivStartE & ~FlushE;
  end

  // Status outputs decoded from the current state.
  always_comb begin
    FDivDoneE = (state == DONE);
    FDivBusyE = (state == BUSY) | ((state == DONE) & StallM);
  end

  // Next-state and iteration-count logic; flush overrides every transition.
  always_comb begin
    stateNext   = state;
    stepCntNext = StepCnt;
    if (FlushE) begin
      stateNext   = IDLE;
      stepCntNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (FDivStartE) begin
            if (SpecialCaseE) begin
              stateNext   = DONE;
              stepCntNext = '0;
            end else begin
              stateNext   = BUSY;
              stepCntNext = SqrtE ? CW'(SQRTCYCLES - 1) : CW'(DIVCYCLES - 1);
            end
          end
        end
        BUSY: begin
          if (StepCnt == '0) stateNext = DONE;
          else               stepCntNext = StepCnt - 1'b1;
        end
        DONE: begin
          if (!StallM) stateNext = IDLE;
        end
        default: begin
          stateNext   = IDLE;
          stepCntNext = '0;
        end
      endcase
    end
  end

  // State, counter and captured operation attributes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      StepCnt      <= '0;
      SqrtM        <= 1'b0;
      SpecialCaseM <= 1'b0;
    end else begin
      state   <= stateNext;
      StepCnt <= stepCntNext;
      if (IFDivStartE) begin
        SqrtM        <= SqrtE;
        SpecialCaseM <= SpecialCaseE;
      end
    end
  end

endmodule

// File: tb/tb_divsqrt_seq.sv
// tb_divsqrt_seq: directed latency/stall/flush/reset scenarios followed by
// random stimulus, all checked every cycle against a timestamp-based model.
module tb_divsqrt_seq;

  localparam int DV = 14;  // divide busy cycles at the defaults
  localparam int SQ = 15;  // sqrt busy cycles at the defaults

  logic       clk = 1'b0;
  logic       reset, FDivStartE, SqrtE, SpecialCaseE, FlushE, StallM;
  logic       IFDivStartE, FDivBusyE, FDivDoneE, SqrtM, SpecialCaseM;
  logic [3:0] StepCnt;

  int checks = 0;
  int passed = 0;

  divsqrt_seq #(.NF(52), .LOGR(2), .DIVCOPIES(2)) dut (
    .clk(clk), .reset(reset), .FDivStartE(FDivStartE), .SqrtE(SqrtE),
    .SpecialCaseE(SpecialCaseE), .FlushE(FlushE), .StallM(StallM),
    .IFDivStartE(IFDivStartE), .FDivBusyE(FDivBusyE), .FDivDoneE(FDivDoneE),
    .SqrtM(SqrtM), .SpecialCaseM(SpecialCaseM), .StepCnt(StepCnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp)
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    else
      passed++;
  endtask

  // Model: an operation is a start timestamp plus a busy length. Cycle k after
  // the start is busy for 1..lat and done afterwards until released.
  bit modelOn = 0;
  bit active  = 0;
  int startCyc = 0;
  int lat = 0;
  bit mSq = 0, mSp = 0;

  function automatic int phaseOf(input int c);
    int k;
    if (!active) return 0;
    k = c - startCyc;
    if (k >= 1 && k <= lat) return 1;
    return 2;
  endfunction

  always @(posedge clk) begin
    int ph;
    ph = phaseOf(cyc);
    if (reset) begin
      active  <= 0;
      mSq     <= 0;
      mSp     <= 0;
      modelOn <= 1;
    end else if (modelOn) begin
      if (FlushE) active <= 0;
      else if (ph == 0 && FDivStartE) begin
        active   <= 1;
        startCyc <= cyc;
        lat      <= SpecialCaseE ? 0 : (SqrtE ? SQ : DV);
        mSq      <= SqrtE;
        mSp      <= SpecialCaseE;
      end else if (ph == 2 && !StallM) active <= 0;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    int ph;
    if (modelOn) begin
      ph = phaseOf(cyc);
      chk("IFDivStartE", IFDivStartE, (ph == 0 && FDivStartE && !FlushE && !reset) ? 1 : 0);
      chk("FDivBusyE", FDivBusyE, (ph == 1 || (ph == 2 && StallM)) ? 1 : 0);
      chk("FDivDoneE", FDivDoneE, (ph == 2) ? 1 : 0);
      chk("StepCnt", StepCnt, (ph == 1) ? lat - (cyc - startCyc) : 0);
      chk("SqrtM", SqrtM, mSq);
      chk("SpecialCaseM", SpecialCaseM, mSp);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clearIn;
    FDivStartE = 0; SqrtE = 0; SpecialCaseE = 0; FlushE = 0; StallM = 0;
  endtask

  initial begin
    clearIn();
    reset = 1;
    FDivStartE = 1;
    repeat (3) tick();
    #1 chk("lit reset busy", FDivBusyE, 0);
    chk("lit reset done", FDivDoneE, 0);
    chk("lit reset istart", IFDivStartE, 0);
    chk("lit reset cnt", StepCnt, 0);
    clearIn();
    reset = 0;
    tick();

    // Divide latency
    FDivStartE = 1;
    #1 chk("lit div istart", IFDivStartE, 1);
    tick(); clearIn();
    #1 chk("lit div c1 busy", FDivBusyE, 1);
    chk("lit div c1 cnt", StepCnt, 13);
    repeat (13) tick();
    #1 chk("lit div c14 cnt", StepCnt, 0);
    chk("lit div c14 done", FDivDoneE, 0);
    tick();
    #1 chk("lit div c15 done", FDivDoneE, 1);
    chk("lit div c15 busy", FDivBusyE, 0);
    tick();
    #1 chk("lit div c16 done", FDivDoneE, 0);
    tick();

    // Sqrt latency
    FDivStartE = 1; SqrtE = 1;
    tick(); clearIn();
    #1 chk("lit sqrt cnt", StepCnt, 14);
    chk("lit sqrt SqrtM", SqrtM, 1);
    repeat (14) tick();
    #1 chk("lit sqrt c15 busy", FDivBusyE, 1);
    chk("lit sqrt c15 done", FDivDoneE, 0);
    tick();
    #1 chk("lit sqrt c16 done", FDivDoneE, 1);
    repeat (2) tick();

    // Special case
    FDivStartE = 1; SpecialCaseE = 1;
    #1 chk("lit spec istart", IFDivStartE, 1);
    tick(); clearIn();
    #1 chk("lit spec done", FDivDoneE, 1);
    chk("lit spec busy", FDivBusyE, 0);
    chk("lit spec SpecM", SpecialCaseM, 1);
    repeat (2) tick();

    // Stall in DONE
    FDivStartE = 1;
    tick(); clearIn();
    repeat (14) tick();
    StallM = 1;
    #1 chk("lit stall c15 busy", FDivBusyE, 1);
    repeat (2) tick();
    #1 chk("lit stall c17 done", FDivDoneE, 1);
    chk("lit stall c17 busy", FDivBusyE, 1);
    tick(); StallM = 0;
    #1 chk("lit stall c18 busy", FDivBusyE, 0);
    chk("lit stall c18 done", FDivDoneE, 1);
    tick();
    #1 chk("lit stall c19 done", FDivDoneE, 0);
    tick();

    // Flush mid-divide
    FDivStartE = 1;
    tick(); clearIn();
    repeat (4) tick();
    FlushE = 1;
    tick(); FlushE = 0;
    #1 chk("lit flush cnt", StepCnt, 0);
    chk("lit flush busy", FDivBusyE, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      #1 chk("lit flush nodone", FDivDoneE, 0);
    end

    // Flush with start in IDLE
    FlushE = 1; FDivStartE = 1;
    #1 chk("lit flushstart istart", IFDivStartE, 0);
    tick(); clearIn();
    #1 chk("lit flushstart busy", FDivBusyE, 0);
    tick();

    // Reset mid-sqrt
    FDivStartE = 1; SqrtE = 1;
    tick(); clearIn();
    repeat (6) tick();
    reset = 1;
    tick(); reset = 0;
    #1 chk("lit rst busy", FDivBusyE, 0);
    chk("lit rst done", FDivDoneE, 0);
    chk("lit rst cnt", StepCnt, 0);
    chk("lit rst SqrtM", SqrtM, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      #1 chk("lit rst nodone", FDivDoneE, 0);
    end

    // Start held through a divide
    FDivStartE = 1;
    #1 chk("lit hold istart c0", IFDivStartE, 1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      #1 chk("lit hold no restart", IFDivStartE, 0);
    end
    tick();
    #1 chk("lit hold istart c16", IFDivStartE, 1);
    tick(); clearIn();
    repeat (20) tick();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      FDivStartE   = ($urandom_range(0, 99) < 50);
      SqrtE        = $urandom_range(0, 1) == 1;
      SpecialCaseE = ($urandom_range(0, 99) < 15);
      FlushE       = ($urandom_range(0, 99) < 3);
      StallM       = ($urandom_range(0, 99) < 35);
      reset        = ($urandom_range(0, 999) < 5);
      tick();
    end
    clearIn();
    reset = 0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
